// File: rtl/pipe_seq_pkg.sv
// Shared types and helpers for the pipeline sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_seq_pkg;

    // Encoding is visible on the mode port, so the values are fixed.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } pipe_mode_e;

    // Upper bound on the number of stages popcount can handle.
    localparam int unsigned MAX_STAGES = 32;

    function automatic int unsigned popcount(input logic [MAX_STAGES-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_seq_fsm.sv
// Run/halt/single-step mode FSM; go is low only while halted.
// Latency: mode and go change one cycle after step_mode/step are sampled.
// Backpressure: none; go gates every stage enable in the parent.
//
// Ports: clk, rst (sync, active-high), step_mode, step -> go, mode.
module pipe_seq_fsm
    import pipe_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_mode,
    input  logic       step,
    output logic       go,
    output logic [1:0] mode
);

    pipe_mode_e state_q;
    pipe_mode_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                // step is deliberately ignored here
                if (step_mode) state_d = HALT;
            end
            HALT: begin
                // Leaving debug mode wins over a coincident step pulse.
                if (!step_mode)  state_d = RUN;
                else if (step)   state_d = STEP;
            end
            STEP: begin
                // Exactly one advance cycle, step ignored.
                state_d = step_mode ? HALT : RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign go   = (state_q != HALT);
    assign mode = state_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Valid/enable sequencer for a chain of enable-gated register stages.
// Latency: NUM_STAGES cycles from accept to out_valid; 1 word/cycle throughput.
// Backpressure: ready ripples combinationally from out_ready, empty stages always load.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready upstream handshake;
// out_valid/out_ready downstream handshake; flush; step_mode/step debug;
// stage_en per-stage load enables; occupancy, busy, xfer_count, mode status.
module pipe_seq_ctrl
    import pipe_seq_pkg::*;
#(
    parameter  int NUM_STAGES = 2,
    parameter  int CNT_WIDTH  = 16,
    localparam int OCC_WIDTH  = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    input  logic                  step_mode,
    input  logic                  step,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [OCC_WIDTH-1:0]  occupancy,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic [1:0]            mode
);

    logic                  go;
    logic                  advance;
    logic [NUM_STAGES-1:0] v;
    logic [NUM_STAGES-1:0] stage_rdy;
    logic [MAX_STAGES-1:0] v_ext;
    logic                  xfer;

    pipe_seq_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .step_mode (step_mode),
        .step      (step),
        .go        (go),
        .mode      (mode)
    );

    // A stage can take a word when it, or any stage after it, is empty, or
    // when downstream is draining. Written in closed form rather than as a
    // recursive chain so each bit depends only on v and out_ready.
    always_comb begin
        stage_rdy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_rdy[i] = out_ready;
            for (int j = i; j < NUM_STAGES; j++) begin
                if (!v[j]) stage_rdy[i] = 1'b1;
            end
        end
    end

    // rst and flush override everything, then halt gating.
    assign advance   = go && !flush && !rst;
    assign stage_en  = advance ? stage_rdy : '0;
    assign in_ready  = stage_en[0];
    assign out_valid = advance && v[NUM_STAGES-1];
    assign xfer      = out_valid && out_ready;

    // Each enabled stage takes the valid bit of its source, so bubbles
    // propagate as zeros exactly like the external data registers do.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v <= '0;
        end else begin
            if (stage_en[0]) v[0] <= in_valid;
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (stage_en[i]) v[i] <= v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (xfer) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        v_ext = '0;
        v_ext[NUM_STAGES-1:0] = v;
    end

    // Status is forced to idle during reset, even before v has cleared.
    assign occupancy = rst ? '0 : OCC_WIDTH'(popcount(v_ext));
    assign busy      = !rst && (|v);

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic       step_mode;
    logic       step;
    logic [1:0] stage_en;
    logic [1:0] occupancy;
    logic       busy;
    logic [3:0] xfer_count;
    logic [1:0] mode;

    logic [7:0] in_data;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_seq_ctrl #(
        .NUM_STAGES (2),
        .CNT_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .step_mode  (step_mode),
        .step       (step),
        .stage_en   (stage_en),
        .occupancy  (occupancy),
        .busy       (busy),
        .xfer_count (xfer_count),
        .mode       (mode)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: external data registers modelled from stage_en, words
    // pushed on accept and popped/compared on each output transfer.
    logic [7:0] q[$];
    logic [7:0] d0, d1;
    logic [7:0] data_s;
    logic [1:0] en_s = 2'b00;

    always @(negedge clk) begin
        en_s   = stage_en;
        data_s = in_data;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    check("sb_data", {24'd0, d1}, {24'd0, q[0]});
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    always @(posedge clk) begin
        if (en_s[1]) d1 <= d0;
        if (en_s[0]) d0 <= data_s;
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        flush = 1'b0; step_mode = 1'b0; step = 1'b0; in_data = 8'h00;

        // Reset held for two cycles with input offered
        #1;
        check("rst_en0", stage_en, 2'b00);
        check("rst_inrdy0", in_ready, 0);
        check("rst_ov0", out_valid, 0);
        check("rst_occ0", occupancy, 0);
        check("rst_busy0", busy, 0);
        tick;
        check("rst_en1", stage_en, 2'b00);
        check("rst_inrdy1", in_ready, 0);
        tick;
        check("rst_mode", mode, 0);
        check("rst_cnt", xfer_count, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rel_en", stage_en, 2'b11);
        check("rel_inrdy", in_ready, 1);
        check("rel_occ", occupancy, 0);
        check("rel_mode", mode, 0);

        // Streaming 20 words, out_ready high
        for (int i = 0; i < 23; i++) begin
            in_valid = (i < 20);
            in_data  = 8'(i + 1);
            #1;
            check("stream_ov", out_valid, (i >= 2 && i < 22) ? 32'd1 : 32'd0);
            if (i < 20) check("stream_inrdy", in_ready, 1);
            tick;
        end
        check("stream_occ", occupancy, 0);
        check("stream_cnt", xfer_count, 4);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40;
        #1; check("bp_inrdy_a", in_ready, 1);
        tick; in_data = 8'h41;
        #1; check("bp_inrdy_b", in_ready, 1);
        tick; in_data = 8'h42;
        #1;
        check("bp_full_inrdy", in_ready, 0);
        check("bp_full_occ", occupancy, 2);
        check("bp_full_en", stage_en, 2'b00);
        check("bp_full_ov", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_release_en", stage_en, 2'b11);
        check("bp_release_inrdy", in_ready, 1);
        tick; in_valid = 1'b0;
        #1; check("bp_occ_after", occupancy, 2);
        tick; tick;
        check("bp_drain_occ", occupancy, 0);
        check("bp_cnt", xfer_count, 7);

        // Bubble collapse
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h50;
        tick; in_valid = 1'b0;
        tick;
        #1;
        check("bub_en", stage_en, 2'b01);
        check("bub_occ", occupancy, 1);
        check("bub_ov", out_valid, 1);
        in_valid = 1'b1; in_data = 8'h51;
        #1; check("bub_inrdy", in_ready, 1);
        tick; in_valid = 1'b0;
        #1;
        check("bub_occ_full", occupancy, 2);
        check("bub_inrdy_full", in_ready, 0);
        out_ready = 1'b1;
        tick; tick;
        check("bub_cnt", xfer_count, 9);

        // Halt and single-step
        in_valid = 1'b1; in_data = 8'h60; step_mode = 1'b1;
        #1; check("step_mode_run", mode, 0);
        tick; in_valid = 1'b0;
        #1;
        check("halt_mode", mode, 1);
        check("halt_en", stage_en, 2'b00);
        check("halt_ov", out_valid, 0);
        check("halt_inrdy", in_ready, 0);
        check("halt_occ", occupancy, 1);
        tick;
        check("halt_hold_occ", occupancy, 1);
        step = 1'b1;
        #1; check("halt_step_en", stage_en, 2'b00);
        tick; step = 1'b0;
        #1;
        check("step1_mode", mode, 2);
        check("step1_en", stage_en, 2'b11);
        check("step1_ov", out_valid, 0);
        tick;
        check("step1_back", mode, 1);
        check("step1_occ", occupancy, 1);
        check("step1_ov_halt", out_valid, 0);
        step = 1'b1;
        tick; step = 1'b0;
        #1;
        check("step2_mode", mode, 2);
        check("step2_ov", out_valid, 1);
        tick;
        check("step2_back", mode, 1);
        check("step2_occ", occupancy, 0);
        check("step2_cnt", xfer_count, 10);
        step_mode = 1'b0;
        tick;
        check("unhalt_mode", mode, 0);
        step = 1'b1;
        tick; step = 1'b0;
        #1; check("run_step_ignored", mode, 0);

        // Flush with a full pipe and both handshakes asserted
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h70;
        tick; in_data = 8'h71;
        tick;
        #1; check("fl_pre_occ", occupancy, 2);
        out_ready = 1'b1; flush = 1'b1; in_data = 8'h72;
        #1;
        check("fl_inrdy", in_ready, 0);
        check("fl_en", stage_en, 2'b00);
        check("fl_ov", out_valid, 0);
        tick; flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_occ", occupancy, 0);
        check("fl_busy", busy, 0);
        check("fl_cnt", xfer_count, 10);
        check("fl_mode", mode, 0);

        // Counter wrap: 10 + 7 = 17 -> 1
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 8'(8'h80 + i);
            tick;
        end
        in_valid = 1'b0;
        tick; tick;
        check("wrap_cnt", xfer_count, 1);

        // Reset mid-stream discards in-flight words
        in_valid = 1'b1; in_data = 8'h90;
        tick; in_data = 8'h91;
        tick;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_en", stage_en, 2'b00);
        tick; rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_occ", occupancy, 0);
        check("post_rst_cnt", xfer_count, 0);
        check("post_rst_mode", mode, 0);
        tick;
        check("sb_leftover", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
